// File: rtl/updown_sweep_ctrl_pkg.sv
// updown_ctrl_defs: state encodings and default widths shared by the sweep controller.
package updown_ctrl_defs;
    localparam int N_DEF  = 4;
    localparam int HW_DEF = 4;
    localparam int SW_DEF = 4;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_t;
endpackage

// File: rtl/updown_sweep_ctrl_timer.sv
// sweep_hold_timer: dwell counter, expires when the count reaches the hold value.
module sweep_hold_timer
    import updown_ctrl_defs::*;
#(
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [HW-1:0] hold,
    output logic          expire
);
    logic [HW-1:0] count;
    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
    assign expire = count == hold;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives an up/down counter through repeated ramp/dwell sweeps
// between a latched low and high limit.
module updown_sweep_ctrl
    import updown_ctrl_defs::*;
#(
    parameter int n  = N_DEF,
    parameter int HW = HW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [n-1:0]  lo,
    input  logic [n-1:0]  hi,
    input  logic [HW-1:0] hold,
    input  logic [SW-1:0] sweeps,
    input  logic [n-1:0]  q,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);
    state_t        state, state_nx;
    logic [n-1:0]  lo_r, hi_r;
    logic [HW-1:0] hold_r;
    logic [SW-1:0] remaining;
    logic          accept, reject, in_hold, expire, last, sweep_end;
    assign accept    = state == IDLE && start && lo < hi;
    assign reject    = state == IDLE && start && !(lo < hi);
    assign in_hold   = state == HOLD_HI || state == HOLD_LO;
    assign last      = remaining == SW'(1);
    assign sweep_end = state == HOLD_LO && expire && !stop;
    assign busy      = state != IDLE;
    // Timer is held clear outside the dwell states so each dwell starts from zero.
    sweep_hold_timer #(.HW(HW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!in_hold),
        .en      (in_hold),
        .hold    (hold_r),
        .expire  (expire)
    );
    always_comb begin
        state_nx = state;
        cnt_en   = 1'b0;
        cnt_up   = 1'b1;
        case (state)
            IDLE:    state_nx = accept ? RAMP_UP : IDLE;
            RAMP_UP: begin
                cnt_en   = q != hi_r;
                state_nx = q == hi_r ? HOLD_HI : RAMP_UP;
            end
            HOLD_HI: state_nx = expire ? RAMP_DN : HOLD_HI;
            RAMP_DN: begin
                cnt_up   = 1'b0;
                cnt_en   = q != lo_r;
                state_nx = q == lo_r ? HOLD_LO : RAMP_DN;
            end
            HOLD_LO: begin
                cnt_up   = 1'b0;
                state_nx = expire ? (last ? IDLE : RAMP_UP) : HOLD_LO;
            end
            default: state_nx = IDLE;
        endcase
        if (stop) cnt_en = 1'b0;
        if (stop && state != IDLE) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            hold_r    <= '0;
            remaining <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            done    <= sweep_end && last;
            cfg_err <= reject;
            if (accept) begin
                lo_r      <= lo;
                hi_r      <= hi;
                hold_r    <= hold;
                remaining <= sweeps;
            end else if (sweep_end && !last && remaining != '0)
                remaining <= remaining - 1'b1;
        end
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: scoreboard bench; each start pushes the expected per-run
// summary, a monitor pops it when the run ends (busy falls or cfg_err pulses).
module tb_updown_sweep_ctrl;
    logic       clk = 0, reset_n = 0, start = 0, stop = 0;
    logic [3:0] lo = 0, hi = 0, hold = 0, sweeps = 0, q;
    logic       cnt_en, cnt_up, busy, done, cfg_err;
    logic       ld = 0;
    logic [3:0] ld_val = 0;
    int         tests = 0, failed = 0;

    typedef struct {
        int dn, err, blen, elen, ulen, qe, qmn, qmx;
    } exp_t;
    exp_t sb[$];

    updown_sweep_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .lo(lo), .hi(hi), .hold(hold), .sweeps(sweeps), .q(q),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Behavioural up/down counter with a bench-side preload.
    always_ff @(posedge clk) begin
        if (ld)
            q <= ld_val;
        else if (cnt_en)
            q <= cnt_up ? q + 4'd1 : q - 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int  blen = 0, elen = 0, ulen = 0, dcnt = 0, qmn = 15, qmx = 0;
    logic pbusy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done) dcnt++;
        if (busy) begin
            blen++;
            if (cnt_en) elen++;
            if (cnt_en && cnt_up) ulen++;
            if (int'(q) < qmn) qmn = int'(q);
            if (int'(q) > qmx) qmx = int'(q);
        end
        if ((pbusy && !busy) || cfg_err) begin
            if (sb.size() == 0)
                chk("unexpected_run_end", 1, 0);
            else begin
                e = sb.pop_front();
                chk("done_pulses", dcnt, e.dn);
                chk("cfg_err", int'(cfg_err), e.err);
                chk("busy_cycles", blen, e.blen);
                chk("en_cycles", elen, e.elen);
                chk("up_en_cycles", ulen, e.ulen);
                chk("q_end", int'(q), e.qe);
                chk("q_min", qmn, e.qmn);
                chk("q_max", qmx, e.qmx);
            end
            blen = 0; elen = 0; ulen = 0; dcnt = 0; qmn = 15; qmx = 0;
        end
        pbusy = busy;
    end

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic load(input logic [3:0] v);
        ld = 1; ld_val = v;
        cyc(1);
        ld = 0;
    endtask

    task automatic go(input logic [3:0] l, h, hd, sw);
        lo = l; hi = h; hold = hd; sweeps = sw; start = 1;
        cyc(1);
        start = 0; stop = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && busy; i++) cyc(1);
        chk("idle_timeout", int'(busy), 0);
        cyc(1);
    endtask

    task automatic wait_for(input logic up, input logic [3:0] qv);
        int i;
        for (i = 0; i < 100; i++) begin
            if (busy && cnt_up == up && q == qv) break;
            cyc(1);
        end
        chk("wait_timeout", int'(i < 100), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_up", int'(cnt_up), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        reset_n = 1;
        load(0);
        // stop alone in IDLE does nothing
        stop = 1; #1;
        chk("idle_stop_en", int'(cnt_en), 0);
        cyc(1);
        stop = 0;
        chk("idle_stop_busy", int'(busy), 0);
        // basic sweep
        sb.push_back('{1, 0, 14, 8, 5, 2, 0, 5});
        go(2, 5, 1, 1);
        chk("first_cycle_en", int'(cnt_en), 1);
        wait_idle();
        // three sweeps
        sb.push_back('{1, 0, 36, 18, 9, 2, 2, 5});
        go(2, 5, 1, 3);
        wait_idle();
        // rejected config
        sb.push_back('{0, 1, 0, 0, 0, 2, 15, 0});
        go(7, 7, 1, 1);
        chk("bad_cfg_busy", int'(busy), 0);
        chk("bad_cfg_en", int'(cnt_en), 0);
        cyc(3);
        // abort in RAMP_DN at q==4
        sb.push_back('{0, 0, 8, 4, 3, 4, 2, 5});
        go(2, 5, 1, 0);
        wait_for(0, 4);
        stop = 1; #1;
        chk("stop_en", int'(cnt_en), 0);
        cyc(1);
        stop = 0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_q", int'(q), 4);
        cyc(3);
        chk("stop_q_frozen", int'(q), 4);
        // reset mid RAMP_UP, counter left at 3
        load(0);
        sb.push_back('{0, 0, 3, 3, 3, 3, 0, 2});
        go(1, 6, 0, 1);
        wait_for(1, 2);
        reset_n = 0;
        cyc(1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_en", int'(cnt_en), 0);
        chk("mid_rst_up", int'(cnt_up), 1);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_q", int'(q), 3);
        reset_n = 1;
        cyc(2);
        sb.push_back('{1, 0, 12, 8, 3, 1, 1, 6});
        go(1, 6, 0, 1);
        wait_idle();
        // wrap through 15->0, start+stop together, start while busy ignored
        load(12);
        sb.push_back('{1, 0, 17, 9, 7, 1, 0, 15});
        stop = 1;
        go(1, 3, 2, 1);
        chk("start_beats_stop", int'(busy), 1);
        cyc(3);
        go(0, 9, 0, 2);
        wait_idle();
        cyc(2);
        chk("pending_expectations", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for one up_down_counter instance. Drives its en/up inputs and watches its Q output.
- Makes the counter ramp up to a programmable high limit, dwell there, ramp down to a programmable low limit, dwell there, and repeat for a programmable number of sweeps.
- Sits beside the counter; start/stop and the configuration come from a host or a test sequencer.

Parameters:
- n, 4, counter width; must match the controlled counter.
- HW, 4, hold-count width.
- SW, 4, sweep-count width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  abort; valid in any non-IDLE state.
- lo  in  n  low limit; latched on an accepted start.
- hi  in  n  high limit; latched on an accepted start.
- hold  in  HW  dwell length; latched on an accepted start.
- sweeps  in  SW  number of sweeps; 0 means run until stop. Latched on an accepted start.
- q  in  n  counter Q, fed back.
- cnt_en  out  1  to counter en.
- cnt_up  out  1  to counter up.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, cnt_en=0, cnt_up=1, busy=0, done=0, cfg_err=0; latched config and internal counters cleared.
- States: IDLE, RAMP_UP, HOLD_HI, RAMP_DN, HOLD_LO. Registered state.
- cnt_en and cnt_up are combinational from state, q and stop. cnt_en is forced to 0 whenever stop=1.
- IDLE:
  - cnt_en=0, cnt_up=1.
  - start=1 with lo<hi: latch config, remaining=sweeps, go to RAMP_UP. cnt_en is high in the very next cycle.
  - start=1 with lo>=hi: cfg_err=1 next cycle, stay in IDLE.
- RAMP_UP:
  - cnt_up=1, cnt_en=(q!=hi).
  - When q==hi: go to HOLD_HI and clear the hold timer.
  - If q>hi on entry, the counter wraps 2^n-1 -> 0 and continues up to hi; no special handling.
- HOLD_HI:
  - cnt_en=0, cnt_up=1. Stays hold+1 cycles, then goes to RAMP_DN.
- RAMP_DN:
  - cnt_up=0, cnt_en=(q!=lo).
  - When q==lo: go to HOLD_LO and clear the hold timer.
- HOLD_LO:
  - cnt_en=0, cnt_up=0. Stays hold+1 cycles, then ends the sweep:
  - remaining==1: go to IDLE; done=1 in the first IDLE cycle.
  - remaining==0 (continuous): go to RAMP_UP; remaining unchanged.
  - otherwise: remaining decrements, go to RAMP_UP.
- Dwell: q sits at a limit for hold+2 cycles (1 detect cycle + hold+1 hold cycles).
- stop=1 in a non-IDLE state:
  - cnt_en=0 in that same cycle.
  - IDLE next cycle; done stays 0; the counter freezes at its current value.
- start while busy: ignored. lo/hi/hold/sweeps changes while busy: ignored.
- stop and start together in IDLE: start wins. stop alone in IDLE: no effect.
- Reset mid-sweep: immediate return to reset values at that edge; the counter keeps its own value.

Decomposition:
- Shared header/package updown_ctrl_defs: state encodings (3-bit localparams IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4) and default widths.
- One natural sub-module: sweep_hold_timer. HW-bit counter with clear and enable inputs and an expire output (asserted when count==hold). Reused for both dwell states.

Test Plan:
- Basic sweep: n=4, counter at 0, lo=2, hi=5, hold=1, sweeps=1, start pulse.
  - cnt_en high for 5 cycles, q reaches 5, q held 3 cycles.
  - cnt_up=0 and q steps down to 2 in 3 cycles, q held 3 cycles.
  - busy high 14 cycles; done pulses once; cnt_en never high in HOLD states.
- Multi-sweep: sweeps=3 with the same limits -> exactly 3 up/down cycles, q never outside [2,5] after the first arrival at 5, a single done after the third HOLD_LO.
- Bad config: lo=7, hi=7, start -> cfg_err pulse, busy stays 0, cnt_en stays 0.
- Abort: sweeps=0, stop asserted while q==4 in RAMP_DN -> cnt_en=0 that cycle, IDLE next cycle, q frozen at 4, done=0.
- Reset mid-RAMP_UP (q==3): all outputs return to reset values at the edge; a later start works from q==3.
- Wrap: counter at 12, lo=1, hi=3 -> q runs 12..15, 0..3, then descends to 1; start during busy ignored.
